// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 device-side transmitter.
package ps2_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned FRAME_BITS = 11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        HOLDOFF = 2'd2
    } ps2_state_e;

    // Bit 0 goes on the wire first.
    typedef struct packed {
        logic              stop;
        logic              parity;
        logic [BYTE_W-1:0] data;
        logic              start;
    } ps2_frame_t;

    function automatic logic odd_parity(input logic [BYTE_W-1:0] b);
        return ~^b;
    endfunction

    function automatic ps2_frame_t make_frame(input logic [BYTE_W-1:0] b);
        ps2_frame_t f;
        f.start  = 1'b0;
        f.data   = b;
        f.parity = odd_parity(b);
        f.stop   = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/ps2_device_tx_if.sv
// Byte stream handshake into the PS/2 transmitter (push = in_valid & in_ready).
interface ps2_device_tx_if;
    import ps2_pkg::*;

    logic [BYTE_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/ps2_tx_fifo.sv
// Synchronous byte FIFO with peeked head, registered count and registered ready.
module ps2_tx_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [BYTE_W-1:0]        push_data,
    input  logic                     push,
    output logic                     ready,
    input  logic                     pop,
    output logic [BYTE_W-1:0]        head_c,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   count_next_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    always_comb begin
        push_ok      = push & ready;
        pop_ok       = pop & (count != '0);
        count_next_c = count + CW'(push_ok) - CW'(pop_ok);
        head_c       = mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next_c;
            ready <= (count_next_c != CW'(DEPTH));
        end
    end

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: byte FIFO, open-drain line control, host-inhibit
// detection with automatic retransmit of the head byte.
module ps2_device_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_DIVISOR = 5000,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned IDLE_GAP    = 10000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    ps2_device_tx_if.slave                in_if,
    input  logic                          ps2_clk_in,
    input  logic                          ps2_data_in,
    output logic                          ps2_clk_oe,
    output logic                          ps2_data_oe,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          abort
);

    localparam int unsigned CNT_W = $clog2(CLK_DIVISOR);
    localparam int unsigned GAP_W = $clog2(IDLE_GAP + 1);
    localparam int unsigned IDX_W = $clog2(FRAME_BITS);
    localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIVISOR - 1);
    localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'(CLK_DIVISOR / 2);
    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(CLK_DIVISOR / 4);
    localparam logic [GAP_W-1:0] GAP_FULL   = GAP_W'(IDLE_GAP);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(FRAME_BITS - 1);

    ps2_state_e              state_q, state_n;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_n;
    logic [IDX_W-1:0]        bit_idx_q, bit_idx_n;
    logic [GAP_W-1:0]        gap_q, gap_n;
    logic [FRAME_BITS-1:0]   frame_q, frame_n;
    logic                    clk_oe_n, data_oe_n, abort_n, busy_n;
    logic [1:0]              clk_sync_q, data_sync_q;
    logic                    clk_s, data_s;
    logic                    pop_c;
    logic [BYTE_W-1:0]       head_c;
    logic [CW-1:0]           count_next_c;

    ps2_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_data    (in_if.in_data),
        .push         (in_if.in_valid),
        .ready        (in_if.in_ready),
        .pop          (pop_c),
        .head_c       (head_c),
        .count        (fifo_count),
        .count_next_c (count_next_c)
    );

    // Pad inputs are asynchronous; nothing reads them before the second flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= '0;
            data_sync_q <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
        end
    end

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            bit_idx_q   <= '0;
            gap_q       <= '0;
            frame_q     <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            abort       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_n;
            bit_cnt_q   <= bit_cnt_n;
            bit_idx_q   <= bit_idx_n;
            gap_q       <= gap_n;
            frame_q     <= frame_n;
            ps2_clk_oe  <= clk_oe_n;
            ps2_data_oe <= data_oe_n;
            abort       <= abort_n;
            busy        <= busy_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        bit_cnt_n = bit_cnt_q;
        bit_idx_n = bit_idx_q;
        gap_n     = gap_q;
        frame_n   = frame_q;
        pop_c     = 1'b0;
        abort_n   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A host request-to-send (data low) keeps the gap cleared.
                if (clk_s && data_s) begin
                    if (gap_q != GAP_FULL) gap_n = gap_q + GAP_W'(1);
                end else begin
                    gap_n = '0;
                end
                if (gap_q == GAP_FULL && fifo_count != '0) begin
                    state_n   = SEND;
                    bit_cnt_n = '0;
                    bit_idx_n = '0;
                    gap_n     = '0;
                    frame_n   = make_frame(head_c);
                end
            end
            SEND: begin
                if (bit_cnt_q == CNT_SAMPLE && !clk_s) begin
                    state_n = HOLDOFF;
                    abort_n = 1'b1;
                end else if (bit_cnt_q == CNT_LAST) begin
                    bit_cnt_n = '0;
                    if (bit_idx_q == IDX_LAST) begin
                        pop_c   = 1'b1;
                        state_n = IDLE;
                        gap_n   = '0;
                    end else begin
                        bit_idx_n = bit_idx_q + IDX_W'(1);
                        frame_n   = frame_q >> 1;
                    end
                end else begin
                    bit_cnt_n = bit_cnt_q + CNT_W'(1);
                end
            end
            HOLDOFF: begin
                if (clk_s) begin
                    state_n = IDLE;
                    gap_n   = '0;
                end
            end
            default: state_n = IDLE;
        endcase

        // Line enables follow the next state so they change on the same edge.
        clk_oe_n  = (state_n == SEND) && (bit_cnt_n >= CNT_HALF);
        data_oe_n = (state_n == SEND) && !frame_n[0];
        busy_n    = (state_n != IDLE) || (count_next_c != '0);
    end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Scoreboard bench for ps2_device_tx: pushed bytes are queued and checked
// against frames decoded from the open-drain enables.
module tb_ps2_device_tx;

    localparam int unsigned CLK_DIVISOR = 8;
    localparam int unsigned FIFO_DEPTH  = 4;
    localparam int unsigned IDLE_GAP    = 4;
    localparam int unsigned FRAME_CYC   = 11 * CLK_DIVISOR;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       host_clk_low;
    logic       host_data_low;
    logic       ps2_clk_oe, ps2_data_oe, busy, abort;
    logic [2:0] fifo_count;
    wire        ps2_clk_in  = ~(ps2_clk_oe | host_clk_low);
    wire        ps2_data_in = ~(ps2_data_oe | host_data_low);

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    ps2_device_tx_if in_if ();

    ps2_device_tx #(
        .CLK_DIVISOR (CLK_DIVISOR),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .IDLE_GAP    (IDLE_GAP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_if       (in_if),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .fifo_count  (fifo_count),
        .abort       (abort)
    );

    // Expected data_oe per bit (index 0 first on the wire).
    function automatic logic [10:0] exp_oe(input logic [7:0] b);
        logic [10:0] v;
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        v[0] = 1'b1;
        for (int i = 0; i < 8; i++) v[1+i] = ~b[i];
        v[9]  = (ones % 2 == 0) ? 1'b0 : 1'b1;
        v[10] = 1'b0;
        return v;
    endfunction

    task automatic push(input logic [7:0] b, input int budget, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        in_if.in_data  = b;
        in_if.in_valid = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (in_if.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 in_if.in_valid = 1'b0;
        if (ok) exp_q.push_back(b);
    endtask

    task automatic capture(input int budget, output bit found, output logic [10:0] bits,
                           output bit shape_ok, output bit end_ok, output bit busy_after,
                           output int idle_cyc);
        found = 1'b0; bits = '0; shape_ok = 1'b1; end_ok = 1'b0; busy_after = 1'b1; idle_cyc = 0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (ps2_data_oe === 1'b1) found = 1'b1;
            else idle_cyc++;
        end
        if (!found) return;
        for (int c = 0; c < int'(FRAME_CYC); c++) begin
            if (c != 0) @(negedge clk);
            if (c % CLK_DIVISOR == 0) bits[c/CLK_DIVISOR] = ps2_data_oe;
            else if (ps2_data_oe !== bits[c/CLK_DIVISOR]) shape_ok = 1'b0;
            if (ps2_clk_oe !== ((c % CLK_DIVISOR) >= CLK_DIVISOR / 2)) shape_ok = 1'b0;
        end
        @(negedge clk);
        end_ok     = (ps2_clk_oe === 1'b0) && (ps2_data_oe === 1'b0);
        busy_after = busy;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_if.in_valid = 1'b0;
        in_if.in_data  = '0;
        host_clk_low   = 1'b0;
        host_data_low  = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (ps2_clk_oe !== 1'b0) $display("FAIL reset_clk_oe: got %b want 0", ps2_clk_oe); else n_pass++;
        n_checks++; if (ps2_data_oe !== 1'b0) $display("FAIL reset_data_oe: got %b want 0", ps2_data_oe); else n_pass++;
        n_checks++; if (in_if.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_if.in_ready); else n_pass++;
        n_checks++; if (fifo_count !== 3'd0) $display("FAIL reset_fifo_count: got %0d want 0", fifo_count); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (abort !== 1'b0) $display("FAIL reset_abort: got %b want 0", abort); else n_pass++;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_single;
        bit ok, found, shape_ok, end_ok, busy_after;
        logic [10:0] bits, spec_bits, exp_bits;
        int idle_cyc;
        int spec_seq [11] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 0};
        for (int i = 0; i < 11; i++) spec_bits[i] = spec_seq[i][0];
        push(8'h1C, 20, ok);
        capture(200, found, bits, shape_ok, end_ok, busy_after, idle_cyc);
        exp_bits = (exp_q.size() != 0) ? exp_oe(exp_q.pop_front()) : 11'h7FF;
        n_checks++; if (!found) $display("FAIL single_start: got no frame want frame"); else n_pass++;
        n_checks++; if (bits !== spec_bits) $display("FAIL single_1c_bits: got %b want %b", bits, spec_bits); else n_pass++;
        n_checks++; if (bits !== exp_bits) $display("FAIL single_scoreboard: got %b want %b", bits, exp_bits); else n_pass++;
        n_checks++; if (!shape_ok) $display("FAIL single_shape: got irregular bits/clk want 11x(4 low,4 pulled)"); else n_pass++;
        n_checks++; if (!end_ok) $display("FAIL single_length: got lines held after 88 cycles want released"); else n_pass++;
        n_checks++; if (busy_after !== 1'b0) $display("FAIL single_busy: got %b want 0", busy_after); else n_pass++;
    endtask

    task automatic test_parity;
        bit ok, found, shape_ok, end_ok, busy_after;
        logic [10:0] bits, exp_bits;
        int idle_cyc;
        logic [7:0] vals [2] = '{8'hFF, 8'h00};
        foreach (vals[k]) begin
            push(vals[k], 20, ok);
            capture(200, found, bits, shape_ok, end_ok, busy_after, idle_cyc);
            exp_bits = (exp_q.size() != 0) ? exp_oe(exp_q.pop_front()) : 11'h7FF;
            n_checks++; if (!found) $display("FAIL parity_start %h: got no frame want frame", vals[k]); else n_pass++;
            n_checks++; if (bits[9] !== 1'b0) $display("FAIL parity_bit %h: got oe %b want 0", vals[k], bits[9]); else n_pass++;
            n_checks++; if (bits !== exp_bits || !shape_ok) $display("FAIL parity_frame %h: got %b want %b", vals[k], bits, exp_bits); else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] vals [5] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
        fork
            begin
                bit ok;
                for (int i = 0; i < 5; i++) begin
                    push(vals[i], 300, ok);
                    n_checks++; if (!ok) $display("FAIL b2b_accept %0d: got stalled want accepted", i); else n_pass++;
                    if (i == 3) begin
                        @(negedge clk);
                        n_checks++; if (in_if.in_ready !== 1'b0) $display("FAIL b2b_full_ready: got %b want 0", in_if.in_ready); else n_pass++;
                        n_checks++; if (fifo_count !== 3'd4) $display("FAIL b2b_full_count: got %0d want 4", fifo_count); else n_pass++;
                    end
                end
            end
            begin
                bit found, shape_ok, end_ok, busy_after;
                logic [10:0] bits, exp_bits;
                int idle_cyc;
                for (int i = 0; i < 5; i++) begin
                    capture(300, found, bits, shape_ok, end_ok, busy_after, idle_cyc);
                    exp_bits = (exp_q.size() != 0) ? exp_oe(exp_q.pop_front()) : 11'h7FF;
                    n_checks++; if (!found || bits !== exp_bits || !shape_ok) $display("FAIL b2b_frame %0d: got %b want %b", i, bits, exp_bits); else n_pass++;
                    if (i > 0) begin
                        n_checks++; if (idle_cyc + 1 < int'(IDLE_GAP)) $display("FAIL b2b_gap %0d: got %0d want >=%0d", i, idle_cyc + 1, IDLE_GAP); else n_pass++;
                    end
                end
            end
        join
        n_checks++; if (fifo_count !== 3'd0 || busy !== 1'b0) $display("FAIL b2b_drain: got count %0d busy %b want 0 0", fifo_count, busy); else n_pass++;
    endtask

    task automatic test_inhibit;
        bit ok, seen, held, found, shape_ok, end_ok, busy_after;
        logic [10:0] bits, exp_bits;
        int idle_cyc;
        seen = 1'b0;
        held = 1'b1;
        push(8'hA5, 20, ok);
        for (int i = 0; i < 200 && ps2_data_oe !== 1'b1; i++) @(negedge clk);
        repeat (5 * CLK_DIVISOR) @(negedge clk);
        host_clk_low = 1'b1;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge clk);
            if (abort === 1'b1) seen = 1'b1;
        end
        n_checks++; if (!seen) $display("FAIL inhibit_abort: got no pulse want pulse"); else n_pass++;
        n_checks++; if (fifo_count !== 3'd1) $display("FAIL inhibit_count: got %0d want 1", fifo_count); else n_pass++;
        @(negedge clk);
        n_checks++; if (abort !== 1'b0) $display("FAIL inhibit_pulse_len: got %b want 0", abort); else n_pass++;
        n_checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) $display("FAIL inhibit_release: got %b%b want 00", ps2_clk_oe, ps2_data_oe); else n_pass++;
        repeat (20) begin
            @(negedge clk);
            if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) held = 1'b0;
        end
        n_checks++; if (!held) $display("FAIL inhibit_holdoff: got lines driven want released"); else n_pass++;
        host_clk_low = 1'b0;
        capture(200, found, bits, shape_ok, end_ok, busy_after, idle_cyc);
        exp_bits = (exp_q.size() != 0) ? exp_oe(exp_q.pop_front()) : 11'h7FF;
        n_checks++; if (!found || bits !== exp_bits || !shape_ok || !end_ok) $display("FAIL inhibit_resend: got %b want %b", bits, exp_bits); else n_pass++;
        n_checks++; if (fifo_count !== 3'd0) $display("FAIL inhibit_pop: got %0d want 0", fifo_count); else n_pass++;
    endtask

    task automatic test_reset_mid;
        bit ok, quiet, found, shape_ok, end_ok, busy_after;
        logic [10:0] bits, exp_bits;
        int idle_cyc;
        quiet = 1'b1;
        push(8'h11, 20, ok);
        push(8'h22, 20, ok);
        push(8'h33, 20, ok);
        for (int i = 0; i < 200 && ps2_data_oe !== 1'b1; i++) @(negedge clk);
        repeat (3 * CLK_DIVISOR + CLK_DIVISOR / 2 + 1) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) $display("FAIL midrst_release: got %b%b want 00", ps2_clk_oe, ps2_data_oe); else n_pass++;
        n_checks++; if (fifo_count !== 3'd0) $display("FAIL midrst_count: got %0d want 0", fifo_count); else n_pass++;
        n_checks++; if (in_if.in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL midrst_status: got ready %b busy %b want 1 0", in_if.in_ready, busy); else n_pass++;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (150) begin
            @(negedge clk);
            if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        n_checks++; if (!quiet) $display("FAIL midrst_quiet: got activity want none"); else n_pass++;
        push(8'h5A, 20, ok);
        capture(200, found, bits, shape_ok, end_ok, busy_after, idle_cyc);
        exp_bits = (exp_q.size() != 0) ? exp_oe(exp_q.pop_front()) : 11'h7FF;
        n_checks++; if (!found || bits !== exp_bits || !shape_ok || !end_ok) $display("FAIL midrst_new_frame: got %b want %b", bits, exp_bits); else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_back_to_back();
        test_inhibit();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
